// File: rtl/or8_way_if.sv
// or8_way_if: bundles the or8_way inputs, clear and observation outputs.
interface or8_way_if;
    logic       clr;
    logic       a, b, c, d, e, f, g, h;
    logic       out;
    logic [3:0] count;
    logic [2:0] first_idx;
    logic       out_q;
    logic       sticky;
    logic [7:0] mask_q;
    modport master (
        output clr, a, b, c, d, e, f, g, h,
        input  out, count, first_idx, out_q, sticky, mask_q
    );
    modport slave (
        input  clr, a, b, c, d, e, f, g, h,
        output out, count, first_idx, out_q, sticky, mask_q
    );
endinterface

// File: rtl/or8_way.sv
// or8_way: eight-input OR with combinational popcount/priority index and
// registered, sticky and per-input capture copies.
module or8_way (
    input logic       clk,
    input logic       reset,
    or8_way_if.slave  bus
);
    logic [7:0] v;
    logic [3:0] cnt;
    assign v = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};
    assign bus.out = |v;
    assign bus.count = cnt;
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, v[i]};
    end
    // a (bit 7) has highest priority; 0 when nothing is set, qualify with out
    assign bus.first_idx = v[7] ? 3'd7 : v[6] ? 3'd6 : v[5] ? 3'd5 : v[4] ? 3'd4 :
                           v[3] ? 3'd3 : v[2] ? 3'd2 : v[1] ? 3'd1 : 3'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_q  <= 1'b0;
            bus.sticky <= 1'b0;
            bus.mask_q <= '0;
        end else begin
            bus.out_q  <= |v;
            bus.sticky <= bus.clr ? 1'b0 : bus.sticky | (|v);
            bus.mask_q <= bus.clr ? 8'h00 : bus.mask_q | v;
        end
    end
endmodule

// File: tb/tb_or8_way.sv
// tb_or8_way: directed checks of combinational and registered or8_way outputs.
module tb_or8_way;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n = 0;
    int   errs = 0;
    or8_way_if bus ();
    or8_way dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic setv(input logic [7:0] x);
        {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h} = x;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [2:0] prio(input logic [7:0] x);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (x[i]) r = 3'(i);
        return r;
    endfunction
    logic [7:0] pat [8]  = '{8'h05, 8'hA0, 8'h18, 8'h7F, 8'h0C, 8'h81, 8'h3C, 8'h11};
    logic [3:0] pcnt [8] = '{4'd2, 4'd2, 4'd2, 4'd7, 4'd2, 4'd2, 4'd4, 4'd2};
    logic [2:0] pidx [8] = '{3'd2, 3'd7, 3'd4, 3'd6, 3'd3, 3'd7, 3'd5, 3'd4};
    initial begin
        bus.clr = 1'b0;
        setv(8'h00); #1;
        chk("zero_out", bus.out, 0);
        chk("zero_cnt", bus.count, 0);
        chk("zero_idx", bus.first_idx, 0);
        setv(8'h02); #1;
        chk("g_out", bus.out, 1);
        chk("g_cnt", bus.count, 1);
        chk("g_idx", bus.first_idx, 1);
        setv(8'h01); #1;
        chk("h_out", bus.out, 1);
        chk("h_idx", bus.first_idx, 0);
        setv(8'hFF); #1;
        chk("ones_out", bus.out, 1);
        chk("ones_cnt", bus.count, 8);
        chk("ones_idx", bus.first_idx, 7);
        for (int i = 0; i < 8; i++) begin
            setv(pat[i]); #1;
            chk("mix_out", bus.out, 1);
            chk("mix_cnt", bus.count, pcnt[i]);
            chk("mix_idx", bus.first_idx, pidx[i]);
        end
        for (int i = 0; i < 256; i++) begin
            logic [7:0] x = 8'(i);
            setv(x); #1;
            chk("ex_out", bus.out, x != 0);
            chk("ex_cnt", bus.count, 8'($countones(x)));
            chk("ex_idx", bus.first_idx, prio(x));
        end
        setv(8'hFF);
        edge_step();
        chk("rst_outq", bus.out_q, 0);
        chk("rst_sticky", bus.sticky, 0);
        chk("rst_mask", bus.mask_q, 0);
        chk("rst_out", bus.out, 1);
        reset = 1'b0;
        setv(8'h00);
        edge_step();
        chk("s0_outq", bus.out_q, 0);
        chk("s0_sticky", bus.sticky, 0);
        chk("s0_mask", bus.mask_q, 0);
        setv(8'h02);
        edge_step();
        chk("s1_outq", bus.out_q, 1);
        chk("s1_sticky", bus.sticky, 1);
        chk("s1_mask", bus.mask_q, 8'h02);
        setv(8'h00);
        edge_step();
        chk("s2_outq", bus.out_q, 0);
        chk("s2_sticky", bus.sticky, 1);
        chk("s2_mask", bus.mask_q, 8'h02);
        chk("s2_inv", bus.sticky, |bus.mask_q);
        bus.clr = 1'b1;
        setv(8'h80);
        edge_step();
        chk("clr_outq", bus.out_q, 1);
        chk("clr_sticky", bus.sticky, 0);
        chk("clr_mask", bus.mask_q, 0);
        bus.clr = 1'b0;
        edge_step();
        chk("pc_outq", bus.out_q, 1);
        chk("pc_sticky", bus.sticky, 1);
        chk("pc_mask", bus.mask_q, 8'h80);
        setv(8'h24);
        edge_step();
        chk("acc_mask", bus.mask_q, 8'hA4);
        chk("acc_inv", bus.sticky, |bus.mask_q);
        reset = 1'b1;
        bus.clr = 1'b1;
        setv(8'hFF);
        edge_step();
        chk("rc_outq", bus.out_q, 0);
        chk("rc_sticky", bus.sticky, 0);
        chk("rc_mask", bus.mask_q, 0);
        chk("rc_out", bus.out, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
        $finish;
    end
endmodule
